// File: rtl/id_ex_stage_reg_pkg.sv
// id_ex_stage_reg_pkg
//
// Purpose: definitions shared by the ID/EX pipeline register, the control
// decoder and the forwarding unit. Holds the packed control-bundle layout,
// the default hardwired-zero register index and the per-cycle update action
// type used by the pipeline register.
//
// Control bundle layout (11 bits, MSB first):
//   [10] regwrite  [9] alusrc  [8] branch  [7] uncondbranch
//   [6]  memread   [5] memwrite  [4] mem2reg  [3:0] aluop
package id_ex_stage_reg_pkg;

    localparam int CTRL_BUNDLE_W     = 11;

    localparam int CTRL_REGWRITE     = 10;
    localparam int CTRL_ALUSRC       = 9;
    localparam int CTRL_BRANCH       = 8;
    localparam int CTRL_UNCONDBRANCH = 7;
    localparam int CTRL_MEMREAD      = 6;
    localparam int CTRL_MEMWRITE     = 5;
    localparam int CTRL_MEM2REG      = 4;
    localparam int CTRL_ALUOP_MSB    = 3;
    localparam int CTRL_ALUOP_LSB    = 0;

    // X31 reads as zero, so it must never be forwarded or refreshed.
    localparam int ZERO_REG_DEFAULT  = 31;

    // What the pipeline register does on the next rising edge when not in reset.
    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_FLUSH = 2'd2
    } update_action_t;

endpackage

// File: rtl/id_ex_stage_reg_sat_counter.sv
// sat_counter
//
// Purpose: event counter that stops at all-ones instead of wrapping. Only
// reset clears it.
//
// Ports:
//   clk    in  1  clock, rising edge
//   reset  in  1  synchronous, active-high clear
//   inc    in  1  count one event this cycle
//   count  out W  current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Increment only while below all-ones so the value sticks at saturation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg
//
// Purpose: decode-to-execute pipeline register. Captures the decoded
// instruction each cycle, holds it on stall (while refreshing held operands
// from the writeback port), replaces it with a bubble on flush, and forwards
// a same-cycle writeback into the captured operands. Counts stall cycles and
// inserted bubbles with saturating counters.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   in_valid, in_ctrl, in_rd        decode slot: valid, control bundle, dest reg
//   in_src_addr, in_src_data        NUM_SRC source indices / operands, slot i at [i*W +: W]
//   in_imm, in_pc                   sign-extended immediate and instruction PC
//   stall, flush                    hold contents / insert bubble (flush wins)
//   wb_en, wb_addr, wb_data         writeback port used for bypass and refresh
//   out_*                           registered copies of the decode fields
//   stall_count, bubble_count       saturating event counters
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int RA_W     = 5,
    parameter int NUM_SRC  = 2,
    parameter int CTRL_W   = CTRL_BUNDLE_W,
    parameter int ZERO_REG = ZERO_REG_DEFAULT,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [RA_W-1:0]           in_rd,
    input  logic [NUM_SRC*RA_W-1:0]   in_src_addr,
    input  logic [NUM_SRC*DATA_W-1:0] in_src_data,
    input  logic [DATA_W-1:0]         in_imm,
    input  logic [DATA_W-1:0]         in_pc,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      wb_en,
    input  logic [RA_W-1:0]           wb_addr,
    input  logic [DATA_W-1:0]         wb_data,
    output logic                      out_valid,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [RA_W-1:0]           out_rd,
    output logic [NUM_SRC*RA_W-1:0]   out_src_addr,
    output logic [NUM_SRC*DATA_W-1:0] out_src_data,
    output logic [DATA_W-1:0]         out_imm,
    output logic [DATA_W-1:0]         out_pc,
    output logic [CNT_W-1:0]          stall_count,
    output logic [CNT_W-1:0]          bubble_count
);

    localparam logic [RA_W-1:0] ZERO_ADDR = RA_W'(ZERO_REG);

    logic                      r_valid;
    logic [CTRL_W-1:0]         r_ctrl;
    logic [RA_W-1:0]           r_rd;
    logic [NUM_SRC*RA_W-1:0]   r_srcAddr;
    logic [NUM_SRC*DATA_W-1:0] r_srcData;
    logic [DATA_W-1:0]         r_imm;
    logic [DATA_W-1:0]         r_pc;

    update_action_t            w_action;
    logic                      w_wbUsable;
    logic [NUM_SRC*DATA_W-1:0] w_loadData;
    logic [NUM_SRC*DATA_W-1:0] w_holdData;
    logic                      w_stallInc;
    logic                      w_bubbleInc;

    // Flush beats stall, stall beats load; reset is handled in the register itself.
    always_comb begin
        w_action = ACT_LOAD;
        if (flush) begin
            w_action = ACT_FLUSH;
        end else if (stall) begin
            w_action = ACT_HOLD;
        end
    end

    // A write to the zero register carries no architectural value.
    assign w_wbUsable = wb_en && (wb_addr != ZERO_ADDR);

    // Per-slot operand selection: forward the writeback into an incoming
    // operand at capture, or into a held operand while stalled. Several slots
    // may name the same register and all of them take the writeback value.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
        logic w_loadMatch;
        logic w_holdMatch;

        assign w_loadMatch = w_wbUsable && in_valid &&
                             (wb_addr == in_src_addr[gi*RA_W +: RA_W]);
        assign w_holdMatch = w_wbUsable && r_valid &&
                             (wb_addr == r_srcAddr[gi*RA_W +: RA_W]);

        assign w_loadData[gi*DATA_W +: DATA_W] =
            w_loadMatch ? wb_data : in_src_data[gi*DATA_W +: DATA_W];
        assign w_holdData[gi*DATA_W +: DATA_W] =
            w_holdMatch ? wb_data : r_srcData[gi*DATA_W +: DATA_W];
    end

    // Pipeline register. A load of an invalid slot squashes the control bundle
    // so downstream stages never act on stale decode signals; the remaining
    // fields load unchanged because nothing downstream qualifies on them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_rd      <= '0;
            r_srcAddr <= '0;
            r_srcData <= '0;
            r_imm     <= '0;
            r_pc      <= '0;
        end else begin
            case (w_action)
                ACT_FLUSH: begin
                    r_valid   <= 1'b0;
                    r_ctrl    <= '0;
                    r_rd      <= '0;
                    r_srcAddr <= '0;
                    r_srcData <= '0;
                    r_imm     <= '0;
                    r_pc      <= '0;
                end
                ACT_HOLD: begin
                    r_srcData <= w_holdData;
                end
                default: begin
                    r_valid   <= in_valid;
                    r_ctrl    <= in_valid ? in_ctrl : '0;
                    r_rd      <= in_rd;
                    r_srcAddr <= in_src_addr;
                    r_srcData <= w_loadData;
                    r_imm     <= in_imm;
                    r_pc      <= in_pc;
                end
            endcase
        end
    end

    // A cycle with both stall and flush is a bubble, not a stall.
    assign w_stallInc  = (w_action == ACT_HOLD);
    assign w_bubbleInc = (w_action == ACT_FLUSH);

    sat_counter #(.W(CNT_W)) u_stallCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stallInc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_bubbleCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_bubbleInc),
        .count (bubble_count)
    );

    assign out_valid    = r_valid;
    assign out_ctrl     = r_ctrl;
    assign out_rd       = r_rd;
    assign out_src_addr = r_srcAddr;
    assign out_src_data = r_srcData;
    assign out_imm      = r_imm;
    assign out_pc       = r_pc;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg
//
// Directed bench for id_ex_stage_reg. A default-width instance and a 4-bit
// counter instance share every input; the narrow one shows counter saturation.
module tb_id_ex_stage_reg;

    localparam int DATA_W = 64;
    localparam int RA_W   = 5;
    localparam int NS     = 2;
    localparam int CTRL_W = 11;

    logic                   clk;
    logic                   reset;
    logic                   inValid;
    logic [CTRL_W-1:0]      inCtrl;
    logic [RA_W-1:0]        inRd;
    logic [NS*RA_W-1:0]     inSrcAddr;
    logic [NS*DATA_W-1:0]   inSrcData;
    logic [DATA_W-1:0]      inImm;
    logic [DATA_W-1:0]      inPc;
    logic                   stall;
    logic                   flush;
    logic                   wbEn;
    logic [RA_W-1:0]        wbAddr;
    logic [DATA_W-1:0]      wbData;

    logic                   outValid;
    logic [CTRL_W-1:0]      outCtrl;
    logic [RA_W-1:0]        outRd;
    logic [NS*RA_W-1:0]     outSrcAddr;
    logic [NS*DATA_W-1:0]   outSrcData;
    logic [DATA_W-1:0]      outImm;
    logic [DATA_W-1:0]      outPc;
    logic [15:0]            stallCount;
    logic [15:0]            bubbleCount;

    logic                   satValid;
    logic [CTRL_W-1:0]      satCtrl;
    logic [RA_W-1:0]        satRd;
    logic [NS*RA_W-1:0]     satSrcAddr;
    logic [NS*DATA_W-1:0]   satSrcData;
    logic [DATA_W-1:0]      satImm;
    logic [DATA_W-1:0]      satPc;
    logic [3:0]             satStallCount;
    logic [3:0]             satBubbleCount;

    int vectors;
    int miscompares;
    int expStall;
    int expBubble;

    id_ex_stage_reg dut (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_ctrl(inCtrl), .in_rd(inRd),
        .in_src_addr(inSrcAddr), .in_src_data(inSrcData), .in_imm(inImm), .in_pc(inPc),
        .stall(stall), .flush(flush), .wb_en(wbEn), .wb_addr(wbAddr), .wb_data(wbData),
        .out_valid(outValid), .out_ctrl(outCtrl), .out_rd(outRd),
        .out_src_addr(outSrcAddr), .out_src_data(outSrcData), .out_imm(outImm),
        .out_pc(outPc), .stall_count(stallCount), .bubble_count(bubbleCount)
    );

    id_ex_stage_reg #(.CNT_W(4)) dutSat (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_ctrl(inCtrl), .in_rd(inRd),
        .in_src_addr(inSrcAddr), .in_src_data(inSrcData), .in_imm(inImm), .in_pc(inPc),
        .stall(stall), .flush(flush), .wb_en(wbEn), .wb_addr(wbAddr), .wb_data(wbData),
        .out_valid(satValid), .out_ctrl(satCtrl), .out_rd(satRd),
        .out_src_addr(satSrcAddr), .out_src_data(satSrcData), .out_imm(satImm),
        .out_pc(satPc), .stall_count(satStallCount), .bubble_count(satBubbleCount)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Quiet inputs: no stall, flush, writeback or valid instruction.
    task automatic applyStimulus();
        reset     = 1'b0;
        inValid   = 1'b0;
        inCtrl    = '0;
        inRd      = '0;
        inSrcAddr = '0;
        inSrcData = '0;
        inImm     = '0;
        inPc      = '0;
        stall     = 1'b0;
        flush     = 1'b0;
        wbEn      = 1'b0;
        wbAddr    = '0;
        wbData    = '0;
    endtask

    // One rising edge; the expected counter values follow the applied controls.
    // Outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            expStall  = 0;
            expBubble = 0;
        end else if (flush) begin
            expBubble++;
        end else if (stall) begin
            expStall++;
        end
        #1;
    endtask

    task automatic test_reset();
        applyStimulus();
        inValid   = 1'b1;
        inCtrl    = 11'h7FF;
        inRd      = 5'd9;
        inSrcAddr = {5'd4, 5'd6};
        inSrcData = {64'hDEAD, 64'hBEEF};
        inImm     = 64'h77;
        inPc      = 64'h100;
        tick();
        stall = 1'b1;
        tick();
        stall = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        inValid = 1'b0;
        vectors++;
        if ({outValid, outCtrl, outRd, outSrcAddr} !== '0 || outSrcData !== '0 ||
            outImm !== '0 || outPc !== '0) begin
            $display("[TB] FAIL reset_fields: valid=%0b ctrl=%h rd=%0d addr=%h data=%h imm=%h pc=%h, required all 0",
                     outValid, outCtrl, outRd, outSrcAddr, outSrcData, outImm, outPc);
            miscompares++;
        end
        vectors++;
        if (stallCount !== 16'd0 || bubbleCount !== 16'd0) begin
            $display("[TB] FAIL reset_counters: stall=%0d bubble=%0d, required 0 0", stallCount, bubbleCount);
            miscompares++;
        end
        vectors++;
        if (satStallCount !== 4'd0 || satBubbleCount !== 4'd0 || satValid !== 1'b0) begin
            $display("[TB] FAIL reset_narrow: stall=%0d bubble=%0d valid=%0b, required 0 0 0",
                     satStallCount, satBubbleCount, satValid);
            miscompares++;
        end
    endtask

    task automatic test_plain_load();
        applyStimulus();
        inValid   = 1'b1;
        inCtrl    = 11'h5A3;
        inRd      = 5'd7;
        inSrcAddr = {5'd2, 5'd1};
        inSrcData = {64'hAA, 64'h55};
        inImm     = 64'hFFFF_FFFF_FFFF_FFF8;
        inPc      = 64'h40;
        tick();
        vectors++;
        if (outPc !== 64'h40 || outSrcData !== {64'hAA, 64'h55}) begin
            $display("[TB] FAIL load_pc_data: pc=%h data=%h, required pc=40 data=%h",
                     outPc, outSrcData, {64'hAA, 64'h55});
            miscompares++;
        end
        vectors++;
        if (outValid !== 1'b1 || outCtrl !== 11'h5A3 || outRd !== 5'd7 ||
            outSrcAddr !== {5'd2, 5'd1} || outImm !== 64'hFFFF_FFFF_FFFF_FFF8) begin
            $display("[TB] FAIL load_fields: valid=%0b ctrl=%h rd=%0d addr=%h imm=%h, required 1 5a3 7 %h fffffffffffffff8",
                     outValid, outCtrl, outRd, outSrcAddr, {5'd2, 5'd1}, outImm);
            miscompares++;
        end
    endtask

    task automatic test_bypass();
        applyStimulus();
        inValid   = 1'b1;
        inCtrl    = 11'h401;
        inSrcAddr = {5'd1, 5'd1};
        inSrcData = {64'h11, 64'h22};
        wbEn      = 1'b1;
        wbAddr    = 5'd1;
        wbData    = 64'h1234;
        tick();
        vectors++;
        if (outSrcData !== {64'h1234, 64'h1234}) begin
            $display("[TB] FAIL bypass_both: data=%h, required %h", outSrcData, {64'h1234, 64'h1234});
            miscompares++;
        end
        inSrcAddr = {5'd31, 5'd31};
        wbAddr    = 5'd31;
        tick();
        vectors++;
        if (outSrcData !== {64'h11, 64'h22}) begin
            $display("[TB] FAIL bypass_zero_reg: data=%h, required %h", outSrcData, {64'h11, 64'h22});
            miscompares++;
        end
        inSrcAddr = {5'd4, 5'd9};
        wbAddr    = 5'd4;
        wbData    = 64'hCAFE;
        tick();
        vectors++;
        if (outSrcData !== {64'hCAFE, 64'h22}) begin
            $display("[TB] FAIL bypass_slot1: data=%h, required %h", outSrcData, {64'hCAFE, 64'h22});
            miscompares++;
        end
        // Invalid slot: no forwarding, control squashed, other fields still load.
        inValid   = 1'b0;
        inCtrl    = 11'h3FF;
        inRd      = 5'd12;
        inPc      = 64'h88;
        inSrcAddr = {5'd4, 5'd4};
        tick();
        vectors++;
        if (outValid !== 1'b0 || outCtrl !== 11'h0 || outRd !== 5'd12 || outPc !== 64'h88 ||
            outSrcData !== {64'h11, 64'h22}) begin
            $display("[TB] FAIL load_invalid: valid=%0b ctrl=%h rd=%0d pc=%h data=%h, required 0 0 12 88 %h",
                     outValid, outCtrl, outRd, outPc, outSrcData, {64'h11, 64'h22});
            miscompares++;
        end
    endtask

    task automatic test_stall_refresh();
        applyStimulus();
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        inValid   = 1'b1;
        inCtrl    = 11'h2C5;
        inRd      = 5'd8;
        inSrcAddr = {5'd5, 5'd3};
        inSrcData = {64'h20, 64'h10};
        inImm     = 64'h4;
        inPc      = 64'h200;
        tick();
        // New decode values appear while stalled and must not be captured.
        stall     = 1'b1;
        inCtrl    = 11'h111;
        inRd      = 5'd2;
        inSrcAddr = {5'd6, 5'd7};
        inSrcData = {64'hEE, 64'hFF};
        inPc      = 64'h300;
        tick();
        wbEn   = 1'b1;
        wbAddr = 5'd3;
        wbData = 64'h99;
        tick();
        wbEn = 1'b0;
        tick();
        stall = 1'b0;
        vectors++;
        if (outSrcData !== {64'h20, 64'h99}) begin
            $display("[TB] FAIL stall_refresh_data: data=%h, required %h", outSrcData, {64'h20, 64'h99});
            miscompares++;
        end
        vectors++;
        if (outValid !== 1'b1 || outCtrl !== 11'h2C5 || outRd !== 5'd8 ||
            outSrcAddr !== {5'd5, 5'd3} || outPc !== 64'h200 || outImm !== 64'h4) begin
            $display("[TB] FAIL stall_hold_fields: valid=%0b ctrl=%h rd=%0d addr=%h pc=%h imm=%h, required 1 2c5 8 %h 200 4",
                     outValid, outCtrl, outRd, outSrcAddr, {5'd5, 5'd3}, outPc, outImm);
            miscompares++;
        end
        vectors++;
        if (stallCount !== 16'd3 || stallCount !== 16'(expStall)) begin
            $display("[TB] FAIL stall_count: got %0d, required 3", stallCount);
            miscompares++;
        end
    endtask

    task automatic test_flush_stall();
        applyStimulus();
        stall = 1'b1;
        flush = 1'b1;
        tick();
        vectors++;
        if (outValid !== 1'b0 || outCtrl !== 11'h0 || outRd !== 5'd0 || outSrcAddr !== '0 ||
            outSrcData !== '0 || outPc !== '0 || outImm !== '0) begin
            $display("[TB] FAIL flush_fields: valid=%0b ctrl=%h rd=%0d data=%h pc=%h, required all 0",
                     outValid, outCtrl, outRd, outSrcData, outPc);
            miscompares++;
        end
        vectors++;
        if (bubbleCount !== 16'd1 || stallCount !== 16'd3) begin
            $display("[TB] FAIL flush_counters: bubble=%0d stall=%0d, required 1 3", bubbleCount, stallCount);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus();
        for (int k = 0; k < 3; k++) begin
            inValid   = 1'b1;
            inCtrl    = CTRL_W'(11'h100 + k);
            inRd      = RA_W'(10 + k);
            inPc      = 64'h1000 + 64'(4 * k);
            inSrcData = {64'(k + 100), 64'(k + 200)};
            inSrcAddr = {5'd13, 5'd14};
            tick();
            vectors++;
            if (outPc !== 64'h1000 + 64'(4 * k) || outCtrl !== CTRL_W'(11'h100 + k) ||
                outRd !== RA_W'(10 + k) || outSrcData !== {64'(k + 100), 64'(k + 200)}) begin
                $display("[TB] FAIL back_to_back_%0d: pc=%h ctrl=%h rd=%0d data=%h", k, outPc, outCtrl, outRd, outSrcData);
                miscompares++;
            end
        end
    endtask

    task automatic test_saturation();
        applyStimulus();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stall = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        stall = 1'b0;
        vectors++;
        if (satStallCount !== 4'd15) begin
            $display("[TB] FAIL sat_stall: got %0d, required 15", satStallCount);
            miscompares++;
        end
        vectors++;
        if (stallCount !== 16'd20 || expStall != 20) begin
            $display("[TB] FAIL wide_stall: got %0d, required 20", stallCount);
            miscompares++;
        end
        flush = 1'b1;
        for (int k = 0; k < 17; k++) tick();
        flush = 1'b0;
        vectors++;
        if (satBubbleCount !== 4'd15 || bubbleCount !== 16'd17 || satStallCount !== 4'd15) begin
            $display("[TB] FAIL sat_bubble: narrow=%0d wide=%0d narrow_stall=%0d, required 15 17 15",
                     satBubbleCount, bubbleCount, satStallCount);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        expStall    = 0;
        expBubble   = 0;
        applyStimulus();
        reset = 1'b1;
        tick();
        tick();
        test_reset();
        test_plain_load();
        test_bypass();
        test_stall_refresh();
        test_flush_stall();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
